cmd_decoder: RTL and testbench

CMD_DECODER -- requirements
Module: cmd_decoder

---
 rtl/cmd_pkg.sv | 42 ++++
 rtl/shadow_reg.sv | 38 +++
 rtl/cmd_decoder.sv | 235 +++++++++++++++++++++++
 tb/tb_cmd_decoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared definitions for the UART command decoder: opcodes, load-FSM states
// and the payload values that select which shadow a RESET command restores.
package cmd_pkg;

    typedef enum logic [3:0] {
        OP_RESET       = 4'd0,
        OP_LOAD_INT    = 4'd1,
        OP_LOAD_SAMPLE = 4'd2,
        OP_LOAD_LINE   = 4'd3,
        OP_ENABLE      = 4'd12,
        OP_COMMIT      = 4'd13
    } opcode_t;

    // The state remembers which shadow register the nibble stream is filling.
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_LOAD_INT    = 2'd1,
        ST_LOAD_SAMPLE = 2'd2,
        ST_LOAD_LINE   = 2'd3
    } state_t;

    // RESET-command payloads; any other payload restores nothing.
    localparam logic [3:0] RST_SEL_INT     = 4'd1;
    localparam logic [3:0] RST_SEL_SAMPLE  = 4'd2;
    localparam logic [3:0] RST_SEL_LINE    = 4'd3;
    localparam logic [3:0] RST_SEL_ENABLES = 4'd12;

    localparam int NIBBLE_W = 4;

    // Map a LOAD_x opcode onto the FSM state that owns its nibble stream.
    function automatic state_t load_target(input logic [3:0] op);
        state_t st;
        case (op)
            OP_LOAD_INT:    st = ST_LOAD_INT;
            OP_LOAD_SAMPLE: st = ST_LOAD_SAMPLE;
            OP_LOAD_LINE:   st = ST_LOAD_LINE;
            default:        st = ST_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/shadow_reg.sv
// One shadow/live register pair. The shadow is written by the decoder one
// command at a time; the live copy only follows the shadow on a commit strobe,
// so a multi-byte update never appears half-finished on the outputs.
module shadow_reg #(
    parameter int           W    = 1,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_data,
    input  logic         i_commit,
    output logic [W-1:0] o_shadow,
    output logic [W-1:0] o_live
);

    logic [W-1:0] r_shadow;
    logic [W-1:0] r_live;

    // Shadow takes decoder writes; live copies the shadow on commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow <= INIT;
            r_live   <= INIT;
        end else begin
            if (i_load) begin
                r_shadow <= i_load_data;
            end
            if (i_commit) begin
                r_live <= r_shadow;
            end
        end
    end

    assign o_shadow = r_shadow;
    assign o_live   = r_live;

endmodule

// File: rtl/cmd_decoder.sv
// UART command decoder. Each valid byte carries an opcode in [3:0] and a
// payload nibble in [7:4]. LOAD commands assemble wide values nibble by
// nibble into shadow registers; COMMIT publishes every shadow at once.
module cmd_decoder
    import cmd_pkg::*;
#(
    parameter int               WIDTH                    = 64,
    parameter logic [WIDTH-1:0] INITIAL_ACTIVE_LINE      = '0,
    parameter logic [WIDTH-1:0] INITIAL_SAMPLE_TIME      = WIDTH'(20),
    parameter logic [WIDTH-1:0] INITIAL_INTEGRATION_TIME = WIDTH'(20000),
    parameter logic [2:0]       INITIAL_ENABLES          = 3'b000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [WIDTH-1:0] sample_time,
    output logic [WIDTH-1:0] integration_time,
    output logic [WIDTH-1:0] active_line,
    output logic             transmit_enable,
    output logic             integration_clock_enable,
    output logic             sample_clock_enable,
    output logic             commit_pulse,
    output logic             cmd_error
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    // Index left behind after the first nibble of a fresh load sequence.
    localparam logic [IDX_W-1:0] IDX_AFTER_FIRST = (NIBBLES > 1) ? IDX_W'(1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST        = IDX_W'(NIBBLES - 1);

    logic [3:0]       w_opcode;
    logic [3:0]       w_payload;

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic [IDX_W-1:0] w_idx_inc;
    logic [IDX_W-1:0] w_nib_idx;

    logic             r_commit_pulse;
    logic             r_cmd_error;
    logic             w_commit;
    logic             w_error;

    logic             w_ld_int;
    logic             w_ld_sample;
    logic             w_ld_line;
    logic             w_ld_en;
    logic             w_restore;
    logic [2:0]       w_en_data;

    logic [WIDTH-1:0] w_sh_int;
    logic [WIDTH-1:0] w_sh_sample;
    logic [WIDTH-1:0] w_sh_line;
    logic [WIDTH-1:0] w_merge_int;
    logic [WIDTH-1:0] w_merge_sample;
    logic [WIDTH-1:0] w_merge_line;
    logic [WIDTH-1:0] w_data_int;
    logic [WIDTH-1:0] w_data_sample;
    logic [WIDTH-1:0] w_data_line;
    logic [2:0]       w_sh_en;
    logic [2:0]       w_live_en;

    assign w_opcode  = rx_data[3:0];
    assign w_payload = rx_data[7:4];

    // The nibble index wraps so the 17th nibble of a stream lands on nibble 0.
    assign w_idx_inc = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);

    // Splice the payload into the addressed nibble of each candidate shadow.
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        logic w_sel;
        assign w_sel = (w_nib_idx == IDX_W'(gi));
        assign w_merge_int[NIBBLE_W*gi +: NIBBLE_W] =
            w_sel ? w_payload : w_sh_int[NIBBLE_W*gi +: NIBBLE_W];
        assign w_merge_sample[NIBBLE_W*gi +: NIBBLE_W] =
            w_sel ? w_payload : w_sh_sample[NIBBLE_W*gi +: NIBBLE_W];
        assign w_merge_line[NIBBLE_W*gi +: NIBBLE_W] =
            w_sel ? w_payload : w_sh_line[NIBBLE_W*gi +: NIBBLE_W];
    end

    // A RESET command loads the initial value instead of a spliced nibble.
    assign w_data_int    = w_restore ? INITIAL_INTEGRATION_TIME : w_merge_int;
    assign w_data_sample = w_restore ? INITIAL_SAMPLE_TIME      : w_merge_sample;
    assign w_data_line   = w_restore ? INITIAL_ACTIVE_LINE      : w_merge_line;

    // Decode one command per valid byte: next FSM state, index and strobes.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_nib_idx    = r_idx;
        w_ld_int     = 1'b0;
        w_ld_sample  = 1'b0;
        w_ld_line    = 1'b0;
        w_ld_en      = 1'b0;
        w_restore    = 1'b0;
        w_en_data    = w_sh_en;
        w_commit     = 1'b0;
        w_error      = 1'b0;

        if (rx_valid) begin
            case (w_opcode)
                OP_RESET: begin
                    w_state_next = ST_IDLE;
                    w_idx_next   = '0;
                    case (w_payload)
                        RST_SEL_INT: begin
                            w_ld_int  = 1'b1;
                            w_restore = 1'b1;
                        end
                        RST_SEL_SAMPLE: begin
                            w_ld_sample = 1'b1;
                            w_restore   = 1'b1;
                        end
                        RST_SEL_LINE: begin
                            w_ld_line = 1'b1;
                            w_restore = 1'b1;
                        end
                        RST_SEL_ENABLES: begin
                            w_ld_en   = 1'b1;
                            w_en_data = INITIAL_ENABLES;
                        end
                        default: ;
                    endcase
                end
                OP_LOAD_INT, OP_LOAD_SAMPLE, OP_LOAD_LINE: begin
                    w_ld_int    = (w_opcode == OP_LOAD_INT);
                    w_ld_sample = (w_opcode == OP_LOAD_SAMPLE);
                    w_ld_line   = (w_opcode == OP_LOAD_LINE);
                    if (r_state == load_target(w_opcode)) begin
                        w_nib_idx  = r_idx;
                        w_idx_next = w_idx_inc;
                    end else begin
                        // Switching targets restarts the stream at nibble 0.
                        w_nib_idx    = '0;
                        w_idx_next   = IDX_AFTER_FIRST;
                        w_state_next = load_target(w_opcode);
                    end
                end
                OP_ENABLE: begin
                    w_ld_en   = 1'b1;
                    w_en_data = w_payload[2:0];
                end
                OP_COMMIT: begin
                    w_commit     = 1'b1;
                    w_state_next = ST_IDLE;
                    w_idx_next   = '0;
                end
                default: begin
                    w_error = 1'b1;
                end
            endcase
        end
    end

    // FSM state, nibble index and the one-cycle status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_commit_pulse <= 1'b0;
            r_cmd_error    <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_idx          <= w_idx_next;
            r_commit_pulse <= w_commit;
            r_cmd_error    <= w_error;
        end
    end

    shadow_reg #(
        .W    (WIDTH),
        .INIT (INITIAL_INTEGRATION_TIME)
    ) u_int (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (w_ld_int),
        .i_load_data (w_data_int),
        .i_commit    (w_commit),
        .o_shadow    (w_sh_int),
        .o_live      (integration_time)
    );

    shadow_reg #(
        .W    (WIDTH),
        .INIT (INITIAL_SAMPLE_TIME)
    ) u_sample (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (w_ld_sample),
        .i_load_data (w_data_sample),
        .i_commit    (w_commit),
        .o_shadow    (w_sh_sample),
        .o_live      (sample_time)
    );

    shadow_reg #(
        .W    (WIDTH),
        .INIT (INITIAL_ACTIVE_LINE)
    ) u_line (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (w_ld_line),
        .i_load_data (w_data_line),
        .i_commit    (w_commit),
        .o_shadow    (w_sh_line),
        .o_live      (active_line)
    );

    // Enable bits: [2] transmit, [1] integration clock, [0] sample clock.
    for (genvar gi = 0; gi < 3; gi++) begin : g_en
        shadow_reg #(
            .W    (1),
            .INIT (INITIAL_ENABLES[gi])
        ) u_en (
            .clk         (clk),
            .reset_n     (reset_n),
            .i_load      (w_ld_en),
            .i_load_data (w_en_data[gi]),
            .i_commit    (w_commit),
            .o_shadow    (w_sh_en[gi]),
            .o_live      (w_live_en[gi])
        );
    end

    assign transmit_enable          = w_live_en[2];
    assign integration_clock_enable = w_live_en[1];
    assign sample_clock_enable      = w_live_en[0];
    assign commit_pulse             = r_commit_pulse;
    assign cmd_error                = r_cmd_error;

endmodule

// File: tb/tb_cmd_decoder.sv
// Bench for cmd_decoder: directed command bytes, a behavioural model of the
// shadow/live values checked every cycle, plus hand-computed literal checks.
module tb_cmd_decoder;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic [63:0] sample_time;
    logic [63:0] integration_time;
    logic [63:0] active_line;
    logic        transmit_enable;
    logic        integration_clock_enable;
    logic        sample_clock_enable;
    logic        commit_pulse;
    logic        cmd_error;

    int n_checks = 0;
    int n_fail   = 0;

    cmd_decoder dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .rx_data                  (rx_data),
        .rx_valid                 (rx_valid),
        .sample_time              (sample_time),
        .integration_time         (integration_time),
        .active_line              (active_line),
        .transmit_enable          (transmit_enable),
        .integration_clock_enable (integration_clock_enable),
        .sample_clock_enable      (sample_clock_enable),
        .commit_pulse             (commit_pulse),
        .cmd_error                (cmd_error)
    );

    always #5 clk = ~clk;

    // Model: index 0 integration_time, 1 sample_time, 2 active_line.
    logic [63:0] m_sh [3];
    logic [63:0] m_lv [3];
    logic [2:0]  m_en_sh;
    logic [2:0]  m_en_lv;
    int          m_tgt;
    int          m_idx;
    logic        m_cp;
    logic        m_err;

    function automatic logic [63:0] init_val(input int i);
        if (i == 0) return 64'd20000;
        if (i == 1) return 64'd20;
        return 64'd0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_sh[i] = init_val(i);
            m_lv[i] = init_val(i);
        end
        m_en_sh = 3'b000;
        m_en_lv = 3'b000;
        m_tgt   = 0;
        m_idx   = 0;
        m_cp    = 1'b0;
        m_err   = 1'b0;
    endtask

    // State the outputs must show after the next rising edge.
    task automatic model_step(input logic v, input logic [7:0] d);
        int         op;
        logic [3:0] p;
        op    = int'(d[3:0]);
        p     = d[7:4];
        m_cp  = 1'b0;
        m_err = 1'b0;
        if (v) begin
            if (op == 0) begin
                if (p == 4'd1)  m_sh[0] = init_val(0);
                if (p == 4'd2)  m_sh[1] = init_val(1);
                if (p == 4'd3)  m_sh[2] = init_val(2);
                if (p == 4'd12) m_en_sh = 3'b000;
                m_tgt = 0;
                m_idx = 0;
            end else if (op >= 1 && op <= 3) begin
                if (m_tgt != op) begin
                    m_tgt = op;
                    m_idx = 0;
                end
                m_sh[op-1][4*m_idx +: 4] = p;
                m_idx = (m_idx + 1) % 16;
            end else if (op == 12) begin
                m_en_sh = p[2:0];
            end else if (op == 13) begin
                for (int i = 0; i < 3; i++) m_lv[i] = m_sh[i];
                m_en_lv = m_en_sh;
                m_cp    = 1'b1;
                m_tgt   = 0;
                m_idx   = 0;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    // Every cycle, just after the rising edge, outputs must match the model.
    always @(posedge clk) begin
        #1;
        chk("integration_time", integration_time, m_lv[0]);
        chk("sample_time", sample_time, m_lv[1]);
        chk("active_line", active_line, m_lv[2]);
        chk("transmit_enable", 64'(transmit_enable), 64'(m_en_lv[2]));
        chk("integration_clock_enable", 64'(integration_clock_enable), 64'(m_en_lv[1]));
        chk("sample_clock_enable", 64'(sample_clock_enable), 64'(m_en_lv[0]));
        chk("commit_pulse", 64'(commit_pulse), 64'(m_cp));
        chk("cmd_error", 64'(cmd_error), 64'(m_err));
    end

    task automatic cycle(input logic v, input logic [7:0] d);
        @(negedge clk);
        rx_valid = v;
        rx_data  = v ? d : 8'($urandom);
        model_step(v, rx_data);
    endtask

    task automatic send(input logic [7:0] d);
        cycle(1'b1, d);
        $display("cmd %02h (op %0d payload %h) at %0t", d, d[3:0], d[7:4], $time);
    endtask

    task automatic idle();
        cycle(1'b0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected end");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        reset_n = 1'b0;
        idle();
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        idle();

        // Reset values
        chk("rst sample_time", sample_time, 64'd20);
        chk("rst integration_time", integration_time, 64'd20000);
        chk("rst active_line", active_line, 64'd0);
        chk("rst enables", 64'({transmit_enable, integration_clock_enable, sample_clock_enable}), 64'd0);
        chk("rst commit_pulse", 64'(commit_pulse), 64'd0);

        // Sample time 0x032 via three nibbles
        send(8'h22); send(8'h32); send(8'h02); send(8'h0D);
        idle();
        chk("lit sample 0x032", sample_time, 64'h32);
        chk("lit commit_pulse high", 64'(commit_pulse), 64'd1);
        idle();
        chk("lit commit_pulse low", 64'(commit_pulse), 64'd0);

        // Interleaved targets restart at nibble 0
        send(8'h51); send(8'h73); send(8'h91); send(8'h0D);
        idle();
        chk("lit interleave int", integration_time, 64'h4E29);
        chk("lit interleave line", active_line, 64'h7);

        // 17 line nibbles: index wraps, 17th overwrites nibble 0
        for (int k = 1; k <= 15; k++) send({4'(k), 4'h3});
        send(8'h03); send(8'hA3); send(8'h0D);
        idle();
        chk("lit wrap line", active_line, 64'h0FED_CBA9_8765_432A);

        // Enables, then RESET of all enables
        send(8'h5C); send(8'h0D);
        idle();
        chk("lit enable 0x5", 64'({transmit_enable, integration_clock_enable, sample_clock_enable}), 64'b101);
        send(8'hC0); send(8'h0D);
        idle();
        chk("lit enable reset", 64'({transmit_enable, integration_clock_enable, sample_clock_enable}), 64'b000);

        // RESET with an unused payload restores nothing; payload 2 restores sample
        send(8'h72); send(8'h50); send(8'h0D);
        idle();
        chk("lit reset nop", sample_time, 64'h37);
        send(8'h20); send(8'h0D);
        idle();
        chk("lit reset sample", sample_time, 64'd20);

        // Enable payload bit 3 ignored
        send(8'hFC); send(8'h0D);
        idle();
        chk("lit enable 0xF", 64'({transmit_enable, integration_clock_enable, sample_clock_enable}), 64'b111);

        // Undefined opcode
        send(8'h37);
        idle();
        chk("lit cmd_error high", 64'(cmd_error), 64'd1);
        chk("lit sample after error", sample_time, 64'd20);
        idle();
        chk("lit cmd_error low", 64'(cmd_error), 64'd0);

        // Reset between two LOAD_SAMPLE nibbles
        send(8'h52);
        @(negedge clk);
        rx_valid = 1'b0;
        reset_n  = 1'b0;
        model_reset();
        #1;
        chk("lit async reset enables", 64'(transmit_enable), 64'd0);
        idle();
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        send(8'h92); send(8'h0D);
        idle();
        chk("lit load after reset", sample_time, 64'h19);
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
